// File: rtl/inv_cipher_iter_pkg.sv
// Shared AES definitions for the iterative inverse cipher.
// Holds the FSM encoding, round count and GF(2^8) helpers.
package inv_cipher_iter_pkg;

    localparam int NR_AES128 = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
    function automatic logic [7:0] gfInv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gfInv(b);
    endfunction

    function automatic logic [31:0] invMixColumn(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        for (int i = 0; i < 4; i++) begin
            o[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
        end
        return o;
    endfunction

endpackage

// File: rtl/inv_cipher_iter_subbytes.sv
// 16-lane inverse byte substitution, one lane per byte [8i+7:8i].
module Subbytes_ins
    import inv_cipher_iter_pkg::*;
(
    input  logic [127:0] i_Data,
    output logic [127:0] o_Data
);

    for (genvar i = 0; i < 16; i++) begin : g_lane
        assign o_Data[8*i+7:8*i] = invSbox(i_Data[8*i+7:8*i]);
    end

endmodule

// File: rtl/inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, 11 cycles per block.
// Round keys come from an external store addressed by o_Rk_idx.
module inv_cipher_iter
    import inv_cipher_iter_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic         i_Start,
    input  logic [127:0] i_Din,
    input  logic [127:0] i_Rk,
    output logic [3:0]   o_Rk_idx,
    output logic         o_Busy,
    output logic         o_Done,
    output logic [127:0] o_Dout
);

    state_t         r_fsm;
    state_t         w_fsmNext;
    logic [3:0]     r_rnd;
    logic [127:0]   r_state;
    logic [127:0]   r_dout;
    logic           r_done;
    logic           r_busy;
    logic [127:0]   w_shifted;
    logic [127:0]   w_sub;
    logic [127:0]   w_ark;
    logic [127:0]   w_mixed;

    function automatic logic [127:0] invShiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    assign w_shifted = invShiftRows(r_state);

    Subbytes_ins u_subbytes (
        .i_Data (w_shifted),
        .o_Data (w_sub)
    );

    // The last round reuses this sum as plaintext, skipping InvMixColumns.
    assign w_ark = w_sub ^ i_Rk;

    always_comb begin
        w_mixed = '0;
        for (int c = 0; c < 4; c++) begin
            w_mixed[127-32*c -: 32] = invMixColumn(w_ark[127-32*c -: 32]);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) r_fsm <= ST_IDLE;
        else          r_fsm <= w_fsmNext;
    end

    always_comb begin
        w_fsmNext = ST_IDLE;
        case (r_fsm)
            ST_IDLE:  w_fsmNext = i_Start ? ST_ROUND : ST_IDLE;
            ST_ROUND: w_fsmNext = (r_rnd == 4'd1) ? ST_FINAL : ST_ROUND;
            ST_FINAL: w_fsmNext = ST_IDLE;
            default:  w_fsmNext = ST_IDLE;
        endcase
    end

    // Key index depends only on FSM state and round count, never on i_Rk.
    always_comb begin
        o_Rk_idx = 4'(NR);
        case (r_fsm)
            ST_IDLE:  o_Rk_idx = 4'(NR);
            ST_ROUND: o_Rk_idx = r_rnd;
            ST_FINAL: o_Rk_idx = 4'd0;
            default:  o_Rk_idx = 4'(NR);
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_rnd   <= '0;
            r_state <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= (r_fsm == ST_FINAL);
            case (r_fsm)
                ST_IDLE: begin
                    if (i_Start) begin
                        r_state <= i_Din ^ i_Rk;
                        r_rnd   <= 4'(NR - 1);
                        r_busy  <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    r_state <= w_mixed;
                    r_rnd   <= r_rnd - 4'd1;
                end
                ST_FINAL: begin
                    r_dout <= w_ark;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_Busy = r_busy;
    assign o_Done = r_done;
    assign o_Dout = r_dout;

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Scoreboard bench for inv_cipher_iter: a forward AES-128 software model
// produces ciphertext/plaintext pairs; a monitor checks every o_Done.
module tb_inv_cipher_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [127:0] data;
        int           dueCycle;
    } exp_t;

    logic         clk;
    logic         rstN;
    logic         start;
    logic [127:0] din;
    logic [127:0] rk;
    logic [3:0]   rkIdx;
    logic         busy;
    logic         done;
    logic [127:0] dout;

    logic [127:0] rkCur [0:10];
    logic [7:0]   sbox  [256];
    exp_t         expQ  [$];
    int           cycleCnt;
    int           checkCnt;
    int           passCnt;
    logic [127:0] lastDout;

    inv_cipher_iter #(.NR(10)) dut (
        .i_Clk    (clk),
        .i_Rst_n  (rstN),
        .i_Start  (start),
        .i_Din    (din),
        .i_Rk     (rk),
        .o_Rk_idx (rkIdx),
        .o_Busy   (busy),
        .o_Done   (done),
        .o_Dout   (dout)
    );

    // External key store: combinational lookup of the requested round key.
    assign rk = (rkIdx <= 4'd10) ? rkCur[rkIdx] : '0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expandKey(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t = t ^ {rcon, 24'h0};
                rcon = gm(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rkCur[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encryptBlock(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rkCur[0][127-8*k -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox[s[k]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = s[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            for (int k = 0; k < 16; k++) s[k] = t[k] ^ rkCur[r][127-8*k -: 8];
        end
        o = '0;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one request; call #1 after a rising edge.
    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] pt, input bit accepted);
        exp_t e;
        start = 1'b1;
        din   = ct;
        @(posedge clk);
        #1;
        if (accepted) begin
            e.data     = pt;
            e.dueCycle = cycleCnt + 10;
            expQ.push_back(e);
        end
        start = 1'b0;
    endtask

    task automatic waitDrained();
        for (int i = 0; i < 40 && expQ.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("done_timeout", 128'(expQ.size()), 128'd0);
    endtask

    always @(negedge clk) begin
        if (!rstN) lastDout = '0;
        if (rstN && done) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 128'(done), 128'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("plaintext", dout, e.data);
                checkOutput("done_cycle", 128'(cycleCnt), 128'(e.dueCycle));
            end
            lastDout = dout;
        end else begin
            checkOutput("dout_stable", dout, lastDout);
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        clk      = 1'b0;
        rstN     = 1'b0;
        start    = 1'b0;
        din      = '0;
        cycleCnt = 0;
        checkCnt = 0;
        passCnt  = 0;
        lastDout = '0;
        buildSbox();
        expandKey(C1_KEY);

        #12;
        checkOutput("reset_busy", 128'(busy), 128'd0);
        checkOutput("reset_done", 128'(done), 128'd0);
        checkOutput("reset_dout", dout, 128'd0);
        checkOutput("reset_rkidx", 128'(rkIdx), 128'd10);

        // Start coincident with the first edge after release; walk the key index.
        @(posedge clk);
        #1;
        rstN = 1'b1;
        checkOutput("rkidx_c0", 128'(rkIdx), 128'd10);
        applyStimulus(C1_CT, C1_PT, 1'b1);
        checkOutput("busy_rise", 128'(busy), 128'd1);
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            checkOutput($sformatf("rkidx_c%0d", k), 128'(rkIdx),
                        128'((k <= 9) ? 10 - k : (k == 10 ? 0 : 10)));
        end
        checkOutput("busy_fall", 128'(busy), 128'd0);
        waitDrained();

        // Back-to-back: second start lands in the o_Done cycle.
        applyStimulus(C1_CT, C1_PT, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("b2b_done_high", 128'(done), 128'd1);
        applyStimulus(C1_CT, C1_PT, 1'b1);
        waitDrained();

        // A start while busy must be ignored.
        applyStimulus(C1_CT, C1_PT, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, '0, 1'b0);
        checkOutput("busy_during_ignored", 128'(busy), 128'd1);
        waitDrained();
        repeat (12) @(posedge clk);
        #1;

        // Reset mid-block aborts without a done pulse.
        applyStimulus(C1_CT, C1_PT, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        expQ.delete();
        checkOutput("abort_busy", 128'(busy), 128'd0);
        checkOutput("abort_dout", dout, 128'd0);
        checkOutput("abort_done", 128'(done), 128'd0);
        checkOutput("abort_rkidx", 128'(rkIdx), 128'd10);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        applyStimulus(C1_CT, C1_PT, 1'b1);
        waitDrained();

        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expandKey(key);
            ct = encryptBlock(pt);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            applyStimulus(ct, pt, 1'b1);
            waitDrained();
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_drained", 128'(expQ.size()), 128'd0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
